// File: rtl/mem_responder_if.sv
// Processor-side bus for mem_responder: word address, write data,
// single-cycle write strobe and registered read data.
interface mem_responder_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (
        output ADDR,
        output DOUT,
        output W,
        input  DIN
    );

    modport slave (
        input  ADDR,
        input  DOUT,
        input  W,
        output DIN
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-mapped responder: 256x16 RAM, LED register, synchronized switches
// and a prescaled down-counting timer, all read back with one cycle latency.
module mem_responder #(
    parameter int PRESCALE = 50000
) (
    input  logic             Clock,
    input  logic             Reset,
    mem_responder_if.slave   bus,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic             tmr_done
);

    localparam logic [3:0]  REGION_RAM = 4'h0;
    localparam logic [3:0]  REGION_LED = 4'h1;
    localparam logic [3:0]  REGION_SW  = 4'h3;
    localparam logic [3:0]  REGION_TMR = 4'h4;
    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0] region;
    logic       sel_ram;
    logic       wr_ram;
    logic       wr_led;
    logic       wr_load;
    logic       wr_ctrl;

    always_comb begin
        region  = bus.ADDR[15:12];
        sel_ram = (region == REGION_RAM);
        wr_ram  = bus.W && sel_ram;
        wr_led  = bus.W && (region == REGION_LED);
        wr_load = bus.W && (region == REGION_TMR) && (bus.ADDR[1:0] == 2'd0);
        wr_ctrl = bus.W && (region == REGION_TMR) && (bus.ADDR[1:0] == 2'd2);
    end

    // ------------------------------------------------------------------
    // RAM: contents survive reset; the read register sees the old word
    // when a write to the same location lands on the same edge.
    // ------------------------------------------------------------------
    logic [15:0] ram [0:255];
    logic [15:0] ram_q_reg;

    always_ff @(posedge Clock) begin
        if (wr_ram) begin
            ram[bus.ADDR[7:0]] <= bus.DOUT;
        end
        ram_q_reg <= ram[bus.ADDR[7:0]];
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [9:0] led_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            led_reg <= '0;
        end else if (wr_led) begin
            led_reg <= bus.DOUT[9:0];
        end
    end

    assign LEDR = led_reg;

    // ------------------------------------------------------------------
    // Two-flop synchronizer, one chain per switch bit
    // ------------------------------------------------------------------
    logic [9:0] sw_meta_reg;
    logic [9:0] sw_sync_reg;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_sw_sync
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    sw_meta_reg[gi] <= 1'b0;
                    sw_sync_reg[gi] <= 1'b0;
                end else begin
                    sw_meta_reg[gi] <= SW[gi];
                    sw_sync_reg[gi] <= sw_meta_reg[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    tmr_state_t  state_reg;
    logic [15:0] load_reg;
    logic [15:0] count_reg;
    logic [15:0] presc_reg;
    logic        en_reg;
    logic        auto_reg;
    logic        done_reg;
    logic        tick;
    logic        expire;

    always_comb begin
        tick   = (state_reg == RUN) && (presc_reg == PRESCALE_MAX);
        // A zero count expires on its first tick just like a count of one.
        expire = tick && (count_reg <= 16'd1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            load_reg  <= '0;
            count_reg <= '0;
            presc_reg <= '0;
            en_reg    <= 1'b0;
            auto_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            if (wr_load) begin
                load_reg <= bus.DOUT;
            end

            case (state_reg)
                IDLE: begin
                    presc_reg <= presc_reg;
                end
                RUN: begin
                    if (tick) begin
                        presc_reg <= '0;
                        if (expire) begin
                            if (auto_reg) begin
                                // Reload uses the LOAD value from before this edge.
                                count_reg <= load_reg;
                            end else begin
                                count_reg <= '0;
                                state_reg <= IDLE;
                                en_reg    <= 1'b0;
                            end
                        end else begin
                            count_reg <= count_reg - 16'd1;
                        end
                    end else begin
                        presc_reg <= presc_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Expiry beats a same-edge write-1-to-clear.
            if (expire) begin
                done_reg <= 1'b1;
            end else if (wr_ctrl && bus.DOUT[2]) begin
                done_reg <= 1'b0;
            end

            if (wr_ctrl) begin
                if (bus.DOUT[0]) begin
                    count_reg <= load_reg;
                    presc_reg <= '0;
                    auto_reg  <= bus.DOUT[1];
                    state_reg <= RUN;
                    en_reg    <= 1'b1;
                end else begin
                    count_reg <= count_reg;
                    presc_reg <= presc_reg;
                    state_reg <= IDLE;
                    en_reg    <= 1'b0;
                end
            end
        end
    end

    assign tmr_done = done_reg;

    // ------------------------------------------------------------------
    // Read path: peripherals are muxed before the register, RAM comes
    // straight from its own read register.
    // ------------------------------------------------------------------
    logic [15:0] periph_rd_next;
    logic [15:0] periph_q_reg;
    logic        rd_ram_reg;

    always_comb begin
        periph_rd_next = '0;
        case (region)
            REGION_LED: periph_rd_next = {6'b0, led_reg};
            REGION_SW:  periph_rd_next = {6'b0, sw_sync_reg};
            REGION_TMR: begin
                case (bus.ADDR[1:0])
                    2'd0:    periph_rd_next = load_reg;
                    2'd1:    periph_rd_next = count_reg;
                    2'd2:    periph_rd_next = {13'b0, done_reg, auto_reg, en_reg};
                    default: periph_rd_next = '0;
                endcase
            end
            default: periph_rd_next = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            periph_q_reg <= '0;
            rd_ram_reg   <= 1'b0;
        end else begin
            periph_q_reg <= periph_rd_next;
            rd_ram_reg   <= sel_ram;
        end
    end

    assign bus.DIN = rd_ram_reg ? ram_q_reg : periph_q_reg;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: PRESCALE, default 50000; number of Clock cycles per timer tick, legal range 1..65535.
REQ-002 Clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high; sampled on the rising edge of Clock.
REQ-004 ADDR  input  16  word address from the processor, held stable for the whole bus cycle.
REQ-005 DOUT  input  16  write data from the processor; valid when W=1.
REQ-006 W  input  1  write strobe; one cycle wide per write.
REQ-007 SW  input  10  asynchronous slide-switch inputs.
REQ-008 DIN  output  16  registered read data to the processor.
REQ-009 LEDR  output  10  LED register contents.
REQ-010 tmr_done  output  1  timer done flag; level output, not a pulse.

Function
REQ-011 Address decode SHALL use ADDR[15:12]:
- 0x0: RAM, 256x16, indexed by ADDR[7:0]; ADDR[11:8] ignored, so addresses alias.
- 0x1: LEDR register.
- 0x3: SW, read-only.
- 0x4: timer, register selected by ADDR[1:0].
- All other values are unmapped.
REQ-012 Writes SHALL occur on the rising edge where W=1, using the ADDR and DOUT values present at that edge.
REQ-013 Writes to SW, to COUNT, or to unmapped space SHALL have no effect.
REQ-014 Read latency SHALL be exactly one cycle: DIN after edge k reflects the location at ADDR before edge k, independent of W.
REQ-015 On a read and write to the same location in the same cycle, DIN SHALL return the old value (read-before-write).
REQ-016 Reads of unmapped addresses and timer offset 3 SHALL return 0x0000.
REQ-017 Reads SHALL have no side effects.
REQ-018 A LEDR write SHALL store DOUT[9:0]; a LEDR read SHALL return {6'b0, LEDR}.
REQ-019 SW SHALL pass through a two-flop synchronizer; a SW read SHALL return {6'b0, SW_sync}.
REQ-020 Timer registers:
- Offset 0, LOAD: read/write.
- Offset 1, COUNT: read-only.
- Offset 2, CTRL: bit0 EN, bit1 AUTO, bit2 DONE.
- CTRL reads return {13'b0, DONE, AUTO, EN}.
REQ-021 The timer FSM SHALL have two states, IDLE and RUN.
REQ-022 A CTRL write with DOUT[0]=1 SHALL load COUNT<=LOAD, clear the prescaler, latch AUTO<=DOUT[1], and enter RUN. This applies even if the timer is already in RUN (restart).
REQ-023 A CTRL write with DOUT[0]=0 SHALL enter IDLE, with COUNT and the prescaler frozen.
REQ-024 A CTRL write with DOUT[2]=1 SHALL clear DONE (write-1-to-clear); DOUT[2]=0 SHALL leave DONE unchanged.
REQ-025 In RUN, the prescaler SHALL count 0..PRESCALE-1; on the cycle it equals PRESCALE-1 it wraps to 0 and a tick occurs.
REQ-026 On a tick with COUNT>1, COUNT SHALL decrement by 1.
REQ-027 On a tick with COUNT==1, the timer SHALL set COUNT<=0 and DONE<=1. It then goes to IDLE with EN=0 if AUTO=0, or sets COUNT<=LOAD and stays in RUN if AUTO=1.
REQ-028 A start with LOAD==0 SHALL set DONE on the first tick and follow the expiry rule in REQ-027.
REQ-029 If expiry and a DONE clear occur on the same edge, DONE SHALL end at 1 (set wins).
REQ-030 If a LOAD write and expiry with AUTO=1 occur on the same edge, COUNT SHALL take the old LOAD value; the new LOAD value is used from the next reload.
REQ-031 tmr_done SHALL equal DONE.

Reset
REQ-032 While Reset=1 at a clock edge, the following SHALL be cleared to 0: DIN, LEDR, LOAD, COUNT, prescaler, EN, AUTO, DONE, and the synchronizer flops; the FSM SHALL go to IDLE.
REQ-033 RAM contents SHALL NOT be cleared by Reset.
REQ-034 Reset asserted in RUN SHALL abort the count, with no DONE set on that edge.
REQ-035 The first access after Reset deasserts SHALL behave normally.

Verification
REQ-036 RAM: write 0xBEEF to 0x0012, then read 0x0012 and 0x0F12 -> DIN=0xBEEF one cycle after each ADDR.
REQ-037 Peripherals:
- Write 0xFFFF to 0x1000 -> LEDR=0x3FF and a read returns 0x03FF.
- SW=0x155 held 3 cycles, read 0x3000 -> 0x0155.
- Read 0x7000 -> 0x0000.
REQ-038 Timer one-shot (PRESCALE=2):
- Write LOAD=3, then CTRL=0x0001.
- tmr_done rises exactly 6 cycles after the CTRL write edge.
- COUNT reads 0 afterwards and CTRL reads 0x0004.
- Writing CTRL=0x0004 clears tmr_done.
REQ-039 Timer auto-reload (PRESCALE=1): LOAD=2, CTRL=0x0003 -> COUNT sequence 2,1,2,1...; DONE set after the 2nd cycle and stays set.
REQ-040 Simultaneous events (PRESCALE=1): write CTRL=0x0004 on the expiry edge -> tmr_done=1. Assert Reset mid-RUN -> COUNT=0, tmr_done=0, and the FSM is in IDLE.
